mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 256-bit off-chip data-memory port between two cache requesters: port 0 is the instruction cache and port 1 is the data cache (dcache_top).
- Sits between the caches and the Data_Memory model.
- Latches one request at a time, drives the memory interface from registers and routes the acknowledge and read data back to the granted port.
- Also provides round-robin or fixed-priority arbitration and a watchdog timeout.

Parameters:
- RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority to port 1.
- TIMEOUT, 64, maximum BUSY cycles before the transaction is aborted (range 2..255).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- p0_enable_i  in  1  port 0 request, held until its ack
- p0_write_i  in  1  port 0 write (1) / read (0)
- p0_addr_i  in  32  port 0 line address
- p0_data_i  in  256  port 0 write data
- p0_data_o  out  256  port 0 read data
- p0_ack_o  out  1  port 0 completion pulse
- p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_data_o, p1_ack_o: same as port 0, for port 1
- mem_data_i  in  256  memory read data
- mem_ack_i  in  1  memory completion pulse
- mem_data_o  out  256  memory write data
- mem_addr_o  out  32  memory address
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  memory write
- grant_o  out  1  currently/last granted port
- timeout_o  out  1  sticky timeout flag

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State = IDLE; mem_enable_o, mem_write_o, p0/p1_ack_o and timeout_o = 0.
  - mem_addr_o and mem_data_o = 0; grant_o = 0; last-granted pointer = 0; watchdog = 0.
  - Reset mid-transaction abandons the transaction with no ack.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - Samples requests every cycle. No request: stay in IDLE.
  - Exactly one port requesting: grant that port.
  - Both requesting, RR_EN=1: grant the port that is not the last-granted one (after reset, port 1 wins the first tie).
  - Both requesting, RR_EN=0: grant port 1.
  - On grant: register the winner's addr/data/write onto mem_addr_o/mem_data_o/mem_write_o; set mem_enable_o=1, grant_o and last-granted pointer to the winner, watchdog=0; go to BUSY.
  - Latency: a request seen at edge E drives mem_enable_o from cycle E+1.
- BUSY:
  - Memory outputs are held constant; requester inputs are ignored, so changes to the granted port's addr/data have no effect.
  - Watchdog increments each cycle.
  - On mem_ack_i=1: the granted port's ack_o = 1 combinationally in the same cycle, and its data_o = mem_data_i. Next state is RELEASE with mem_enable_o=0 and mem_write_o=0.
  - If the watchdog reaches TIMEOUT-1 with no ack: set timeout_o=1 (sticky until reset), pulse the granted port's ack_o for one cycle with data_o = 0, drop mem_enable_o, go to RELEASE.
  - mem_ack_i in the same cycle as the watchdog expiry counts as a normal ack; timeout_o is not set.
- RELEASE:
  - One cycle with mem_enable_o=0 so the memory sees the request drop, then IDLE.
  - Back-to-back transactions are therefore separated by 2 idle cycles on mem_enable_o: ack at T, enable low at T+1 and T+2, high at T+3.
- Non-granted ports: ack_o = 0 and data_o = 0 at all times.
- mem_ack_i outside BUSY is ignored.
- A requester that withdraws its enable during BUSY still receives the ack pulse; the arbiter does not cancel the memory transaction.
- p*_ack_o is never high for more than one cycle per grant. At most one ack is high in any cycle.

Test Plan:
- p1 read at addr 0x0000_0400, memory acks 10 cycles after enable -> mem_enable_o high from cycle +1; mem_addr_o=0x400, mem_write_o=0; p1_ack_o pulses in the ack cycle with p1_data_o = mem_data_i (pattern 0xA5..A5); p0_ack_o stays 0.
- After reset, p0 and p1 assert together (RR_EN=1) -> p1 granted first, then p0, then p1 again while both stay asserted. With RR_EN=0, p1 is granted three times consecutively.
- p0 write to addr 0x20 with data 256'h1234 while p1 requests 1 cycle later -> p0 completes first with mem_write_o=1 and mem_data_o=0x1234 held throughout BUSY. p1 is issued with exactly 2 low cycles on mem_enable_o after p0's ack.
- Memory never acks, TIMEOUT=8 -> the granted port's ack_o pulses in BUSY cycle 8 with data_o=0; timeout_o=1 and stays 1 through subsequent normal transactions until rst_i=0.
- rst_i driven low mid-BUSY, asynchronously between clock edges -> mem_enable_o=0 immediately, no ack pulse. After release, a new p0 request is granted normally.
- Granted requester changes addr from 0x40 to 0x80 and drops its enable during BUSY -> mem_addr_o stays 0x40; ack still pulses once.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two cache requesters, the arbiter and the memory model.
// Signal names follow the original port list so existing hookups map one-to-one.
interface mem_port_arbiter_if;
  logic         p0_enable_i;
  logic         p0_write_i;
  logic [31:0]  p0_addr_i;
  logic [255:0] p0_data_i;
  logic [255:0] p0_data_o;
  logic         p0_ack_o;

  logic         p1_enable_i;
  logic         p1_write_i;
  logic [31:0]  p1_addr_i;
  logic [255:0] p1_data_i;
  logic [255:0] p1_data_o;
  logic         p1_ack_o;

  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;

  logic         grant_o;
  logic         timeout_o;

  // Arbiter side
  modport slave (
    input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
    input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
    input  mem_data_i, mem_ack_i,
    output p0_data_o, p0_ack_o, p1_data_o, p1_ack_o,
    output mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
    output grant_o, timeout_o
  );

  // Requester / memory side
  modport master (
    output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
    output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
    output mem_data_i, mem_ack_i,
    input  p0_data_o, p0_ack_o, p1_data_o, p1_ack_o,
    input  mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
    input  grant_o, timeout_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single 256-bit memory port between the icache (port 0) and dcache (port 1),
// with round-robin or fixed priority arbitration and a BUSY watchdog.
module mem_port_arbiter #(
  parameter bit          RR_EN   = 1'b1,
  parameter int unsigned TIMEOUT = 64
) (
  input logic               clk_i,
  input logic               rst_i,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t       state;
  logic [7:0]   watchdog;
  logic         grant;      // also serves as the round-robin last-granted pointer
  logic [31:0]  mem_addr;
  logic [255:0] mem_data;
  logic         mem_enable;
  logic         mem_write;
  logic         timeout;

  logic         req0;
  logic         req1;
  logic         winner;
  logic         finish;
  logic         expire;
  logic [255:0] rd_data;

  always_comb begin
    req0    = bus.p0_enable_i;
    req1    = bus.p1_enable_i;
    winner  = req1;
    if (req0 && req1) begin
      winner = RR_EN ? ~grant : 1'b1;
    end
    // A memory ack coinciding with watchdog expiry is treated as a normal completion.
    finish  = (state == BUSY) && (bus.mem_ack_i || (watchdog == WD_LAST));
    expire  = finish && !bus.mem_ack_i;
    rd_data = bus.mem_ack_i ? bus.mem_data_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      watchdog   <= '0;
      grant      <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_enable <= 1'b0;
      mem_write  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant      <= winner;
            mem_addr   <= winner ? bus.p1_addr_i  : bus.p0_addr_i;
            mem_data   <= winner ? bus.p1_data_i  : bus.p0_data_i;
            mem_write  <= winner ? bus.p1_write_i : bus.p0_write_i;
            mem_enable <= 1'b1;
            watchdog   <= '0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (finish) begin
            mem_enable <= 1'b0;
            mem_write  <= 1'b0;
            state      <= RELEASE;
            if (expire) begin
              timeout <= 1'b1;
            end
          end else begin
            watchdog <= watchdog + 8'd1;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.p0_ack_o     = finish && !grant;
  assign bus.p1_ack_o     = finish && grant;
  assign bus.p0_data_o    = (finish && !grant) ? rd_data : '0;
  assign bus.p1_data_o    = (finish && grant)  ? rd_data : '0;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_data_o   = mem_data;
  assign bus.mem_enable_o = mem_enable;
  assign bus.mem_write_o  = mem_write;
  assign bus.grant_o      = grant;
  assign bus.timeout_o    = timeout;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: dut A is round-robin with TIMEOUT=64,
// dut B is fixed priority with TIMEOUT=8; a scoreboard checks every ack.
module tb_mem_port_arbiter;

  typedef struct {
    logic         en, wr, a0, a1, g, to;
    logic [31:0]  addr;
    logic [255:0] wdat, d0, d1;
  } snap_t;

  typedef struct {
    logic         port;
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] wdat;
    logic [255:0] rdat;
  } exp_t;

  localparam logic [255:0] PA = {32{8'hA5}};
  localparam logic [255:0] PB = {32{8'h3C}};

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  int unsigned errors = 0;
  int unsigned checks = 0;

  int dly_a = 1, dly_b = 1;
  bit never_a = 1'b0, never_b = 1'b0;
  int cnt_a = 0, cnt_b = 0;

  exp_t q0[$];
  exp_t q1[$];

  mem_port_arbiter_if ia();
  mem_port_arbiter_if ib();

  mem_port_arbiter #(.RR_EN(1'b1), .TIMEOUT(64)) u_a (.clk_i(clk), .rst_i(rst_a), .bus(ia));
  mem_port_arbiter #(.RR_EN(1'b0), .TIMEOUT(8))  u_b (.clk_i(clk), .rst_i(rst_b), .bus(ib));

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk256(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic snap_t snap(input int which);
    snap_t s;
    if (which == 0) begin
      s.en = ia.mem_enable_o; s.wr = ia.mem_write_o; s.a0 = ia.p0_ack_o; s.a1 = ia.p1_ack_o;
      s.g = ia.grant_o; s.to = ia.timeout_o; s.addr = ia.mem_addr_o; s.wdat = ia.mem_data_o;
      s.d0 = ia.p0_data_o; s.d1 = ia.p1_data_o;
    end else begin
      s.en = ib.mem_enable_o; s.wr = ib.mem_write_o; s.a0 = ib.p0_ack_o; s.a1 = ib.p1_ack_o;
      s.g = ib.grant_o; s.to = ib.timeout_o; s.addr = ib.mem_addr_o; s.wdat = ib.mem_data_o;
      s.d0 = ib.p0_data_o; s.d1 = ib.p1_data_o;
    end
    return s;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int which, input bit port, input bit en, input bit wr,
                       input logic [31:0] addr, input logic [255:0] data);
    if (which == 0) begin
      if (port) begin ia.p1_enable_i = en; ia.p1_write_i = wr; ia.p1_addr_i = addr; ia.p1_data_i = data; end
      else      begin ia.p0_enable_i = en; ia.p0_write_i = wr; ia.p0_addr_i = addr; ia.p0_data_i = data; end
    end else begin
      if (port) begin ib.p1_enable_i = en; ib.p1_write_i = wr; ib.p1_addr_i = addr; ib.p1_data_i = data; end
      else      begin ib.p0_enable_i = en; ib.p0_write_i = wr; ib.p0_addr_i = addr; ib.p0_data_i = data; end
    end
  endtask

  task automatic set_en(input int which, input bit port, input bit en);
    if (which == 0) begin
      if (port) ia.p1_enable_i = en; else ia.p0_enable_i = en;
    end else begin
      if (port) ib.p1_enable_i = en; else ib.p0_enable_i = en;
    end
  endtask

  task automatic push(input int which, input bit port, input logic [31:0] addr, input bit wr,
                      input logic [255:0] wdat, input logic [255:0] rdat);
    exp_t e;
    e.port = port; e.addr = addr; e.wr = wr; e.wdat = wdat; e.rdat = rdat;
    if (which == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  function automatic bit acked(input int which, input bit port);
    snap_t s;
    s = snap(which);
    return port ? s.a1 : s.a0;
  endfunction

  task automatic wait_ack(input int which, input bit port, input int budget, output int n);
    n = 0;
    while (!acked(which, port) && n < budget) begin
      tick();
      n++;
    end
    chk1("ack_seen", acked(which, port), 1'b1);
  endtask

  task automatic wait_any(input int which, input int budget, output bit port);
    snap_t s;
    int n;
    n = 0;
    s = snap(which);
    while (!(s.a0 || s.a1) && n < budget) begin
      tick();
      n++;
      s = snap(which);
    end
    chk1("any_ack_seen", s.a0 || s.a1, 1'b1);
    port = s.a1;
  endtask

  // Scoreboard monitor: idle-port quiet, held memory request, ack port/data order.
  task automatic observe(input int which);
    snap_t s;
    exp_t  e;
    bit    have;
    s    = snap(which);
    have = (which == 0) ? (q0.size() != 0) : (q1.size() != 0);
    if (have) e = (which == 0) ? q0[0] : q1[0];
    chk1("idle_port_ack", s.g ? s.a0 : s.a1, 1'b0);
    chk256("idle_port_data", s.g ? s.d0 : s.d1, '0);
    if (s.en && have) begin
      chk1("grant", s.g, e.port);
      chk32("mem_addr", s.addr, e.addr);
      chk1("mem_write", s.wr, e.wr);
      if (e.wr) chk256("mem_wdata", s.wdat, e.wdat);
    end
    if (s.a0 || s.a1) begin
      if (!have) begin
        chk1("spurious_ack", s.a0 || s.a1, 1'b0);
      end else begin
        chk1("ack_port", s.a1, e.port);
        chk256("ack_data", e.port ? s.d1 : s.d0, e.rdat);
        if (which == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_a === 1'b1) observe(0);
  end

  always @(negedge clk) begin
    #1;
    if (rst_b === 1'b1) observe(1);
  end

  always @(negedge clk) begin
    ia.mem_ack_i  = 1'b0;
    ia.mem_data_i = '0;
    if (ia.mem_enable_o === 1'b1 && !never_a) begin
      cnt_a++;
      if (cnt_a == dly_a) begin
        ia.mem_ack_i  = 1'b1;
        ia.mem_data_i = PA;
        cnt_a = 0;
      end
    end else begin
      cnt_a = 0;
    end
  end

  always @(negedge clk) begin
    ib.mem_ack_i  = 1'b0;
    ib.mem_data_i = '0;
    if (ib.mem_enable_o === 1'b1 && !never_b) begin
      cnt_b++;
      if (cnt_b == dly_b) begin
        ib.mem_ack_i  = 1'b1;
        ib.mem_data_i = PB;
        cnt_b = 0;
      end
    end else begin
      cnt_b = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    snap_t s;
    int    n;
    bit    p;

    rst_a = 1'b0;
    rst_b = 1'b0;
    for (int w = 0; w < 2; w++) begin
      drive(w, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(w, 1'b1, 1'b0, 1'b0, '0, '0);
    end
    tick();
    tick();
    for (int w = 0; w < 2; w++) begin
      s = snap(w);
      chk1("rst_en", s.en, 1'b0);
      chk1("rst_wr", s.wr, 1'b0);
      chk1("rst_ack0", s.a0, 1'b0);
      chk1("rst_ack1", s.a1, 1'b0);
      chk1("rst_timeout", s.to, 1'b0);
      chk1("rst_grant", s.g, 1'b0);
      chk32("rst_addr", s.addr, 32'h0);
      chk256("rst_wdata", s.wdat, '0);
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();

    // p1 read, memory acks in the 10th BUSY cycle
    dly_a = 10;
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0000_0400, '0);
    push(0, 1'b1, 32'h400, 1'b0, '0, PA);
    tick();
    s = snap(0);
    chk1("lat_en", s.en, 1'b1);
    chk32("lat_addr", s.addr, 32'h400);
    chk1("lat_wr", s.wr, 1'b0);
    wait_ack(0, 1'b1, 30, n);
    chk32("read_ack_cycle", n, 32'd9);
    set_en(0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      s = snap(0);
      chk1("post_read_en", s.en, 1'b0);
    end

    // round-robin tie after reset: 1, 0, 1
    rst_a = 1'b0;
    tick();
    rst_a = 1'b1;
    dly_a = 3;
    drive(0, 1'b0, 1'b1, 1'b0, 32'h100, '0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h200, '0);
    push(0, 1'b1, 32'h200, 1'b0, '0, PA);
    push(0, 1'b0, 32'h100, 1'b0, '0, PA);
    push(0, 1'b1, 32'h200, 1'b0, '0, PA);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) tick();
      wait_any(0, 20, p);
      chk1("rr_order", p, (k == 1) ? 1'b0 : 1'b1);
    end
    set_en(0, 1'b0, 1'b0);
    set_en(0, 1'b1, 1'b0);
    tick();
    tick();
    chk32("rr_drained", q0.size(), 32'd0);

    // fixed priority: port 1 wins three times
    dly_b = 3;
    drive(1, 1'b0, 1'b1, 1'b0, 32'h110, '0);
    drive(1, 1'b1, 1'b1, 1'b0, 32'h210, '0);
    for (int k = 0; k < 3; k++) push(1, 1'b1, 32'h210, 1'b0, '0, PB);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) tick();
      wait_any(1, 20, p);
      chk1("fp_order", p, 1'b1);
    end
    set_en(1, 1'b0, 1'b0);
    set_en(1, 1'b1, 1'b0);
    tick();
    tick();
    chk32("fp_drained", q1.size(), 32'd0);

    // memory ack on the expiry cycle is a normal completion
    dly_b = 8;
    drive(1, 1'b0, 1'b1, 1'b0, 32'h500, '0);
    push(1, 1'b0, 32'h500, 1'b0, '0, PB);
    tick();
    wait_ack(1, 1'b0, 20, n);
    chk32("edge_ack_cycle", n, 32'd7);
    set_en(1, 1'b0, 1'b0);
    tick();
    s = snap(1);
    chk1("edge_no_timeout", s.to, 1'b0);
    tick();

    // memory never acks: abort in BUSY cycle 8 with zero data, sticky flag
    never_b = 1'b1;
    drive(1, 1'b0, 1'b1, 1'b0, 32'h300, '0);
    push(1, 1'b0, 32'h300, 1'b0, '0, '0);
    tick();
    wait_ack(1, 1'b0, 20, n);
    chk32("to_ack_cycle", n, 32'd7);
    set_en(1, 1'b0, 1'b0);
    tick();
    s = snap(1);
    chk1("to_set", s.to, 1'b1);
    chk1("to_enable_dropped", s.en, 1'b0);
    never_b = 1'b0;
    dly_b = 2;
    drive(1, 1'b1, 1'b1, 1'b1, 32'h310, 256'hBEEF);
    push(1, 1'b1, 32'h310, 1'b1, 256'hBEEF, PB);
    tick();
    wait_ack(1, 1'b1, 20, n);
    set_en(1, 1'b1, 1'b0);
    tick();
    s = snap(1);
    chk1("to_sticky", s.to, 1'b1);
    rst_b = 1'b0;
    #1;
    s = snap(1);
    chk1("to_cleared", s.to, 1'b0);
    tick();
    rst_b = 1'b1;

    // p0 write with p1 arriving a cycle later; two low cycles between grants
    dly_a = 5;
    drive(0, 1'b0, 1'b1, 1'b1, 32'h20, 256'h1234);
    push(0, 1'b0, 32'h20, 1'b1, 256'h1234, PA);
    tick();
    drive(0, 1'b1, 1'b1, 1'b0, 32'h60, '0);
    push(0, 1'b1, 32'h60, 1'b0, '0, PA);
    wait_ack(0, 1'b0, 20, n);
    set_en(0, 1'b0, 1'b0);
    tick();
    n = 0;
    s = snap(0);
    while (!s.en && n < 10) begin
      tick();
      n++;
      s = snap(0);
    end
    chk32("b2b_gap", n, 32'd2);
    wait_ack(0, 1'b1, 20, n);
    set_en(0, 1'b1, 1'b0);
    tick();

    // asynchronous reset in the middle of BUSY
    dly_a = 10;
    drive(0, 1'b0, 1'b1, 1'b0, 32'h700, '0);
    push(0, 1'b0, 32'h700, 1'b0, '0, PA);
    tick();
    tick();
    tick();
    #2;
    rst_a = 1'b0;
    #1;
    s = snap(0);
    chk1("arst_en", s.en, 1'b0);
    chk1("arst_ack", s.a0, 1'b0);
    chk32("arst_addr", s.addr, 32'h0);
    q0.delete();
    set_en(0, 1'b0, 1'b0);
    tick();
    rst_a = 1'b1;
    dly_a = 4;
    drive(0, 1'b0, 1'b1, 1'b0, 32'h700, '0);
    push(0, 1'b0, 32'h700, 1'b0, '0, PA);
    tick();
    s = snap(0);
    chk1("arst_regrant", s.en, 1'b1);
    wait_ack(0, 1'b0, 20, n);
    set_en(0, 1'b0, 1'b0);
    tick();
    tick();

    // requester changes addr and withdraws during BUSY
    dly_a = 6;
    drive(0, 1'b0, 1'b1, 1'b0, 32'h40, '0);
    push(0, 1'b0, 32'h40, 1'b0, '0, PA);
    tick();
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 32'h80, '0);
    s = snap(0);
    chk32("withdraw_addr", s.addr, 32'h40);
    wait_ack(0, 1'b0, 20, n);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      s = snap(0);
      if (s.a0 || s.a1) n++;
    end
    chk32("withdraw_single_ack", n, 32'd0);

    chk32("final_q0", q0.size(), 32'd0);
    chk32("final_q1", q1.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
